dfh_chain_responder: RTL and testbench

Slave-side CSR responder that presents a Device Feature Header (DFH) chain to a host-side DFH walker over a 64-bit AXI4-lite-style CSR port. Each of `NUM_FEAT` features owns a `FEAT_SIZE` byte window:
- Offset 0x0 of each window returns a DFH built from parameters.
- Offset 0x8 is an optional read/write scratch register.
- Feature links are generated automatically; the last feature has EOL set.

The block sits behind the BPF/APF fabric as a leaf slave. It is used as a synthesizable stand-in feature list and as the far end for DFH-walk unit tests.

---
 rtl/dfh_resp_pkg.sv | 34 +++
 rtl/dfh_resp_addr_dec.sv | 23 ++
 rtl/dfh_chain_responder.sv | 152 +++++++++++++++
 tb/tb_dfh_chain_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dfh_resp_pkg.sv
// rtl/dfh_resp_pkg.sv - shared DFH layout, response codes and register offsets for the DFH chain responder.
package dfh_resp_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int DFH_OFF     = 'h0;
  localparam int SCRATCH_OFF = 'h8;

  typedef struct packed {
    logic [3:0]  feat_type;
    logic [18:0] rsvd;
    logic        eol;
    logic [23:0] nxt;
    logic [3:0]  major;
    logic [11:0] id;
  } t_dfh;

  function automatic t_dfh build_dfh(input logic [3:0]  ftype,
                                     input logic [11:0] id,
                                     input logic [3:0]  major,
                                     input logic        eol,
                                     input logic [23:0] nxt);
    t_dfh d;
    d.feat_type = ftype;
    d.rsvd      = '0;
    d.eol       = eol;
    d.nxt       = nxt;
    d.major     = major;
    d.id        = id;
    return d;
  endfunction

endpackage

// File: rtl/dfh_resp_addr_dec.sv
// rtl/dfh_resp_addr_dec.sv - splits a CSR address into feature index and window offset, flags legal accesses.
module dfh_resp_addr_dec #(
  parameter int ADDR_W    = 20,
  parameter int NUM_FEAT  = 4,
  parameter int FEAT_SIZE = 'h1000,
  parameter int REG_W     = $clog2(FEAT_SIZE),
  parameter int FIDX_W    = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [FIDX_W-1:0] feat_o,
  output logic [REG_W-1:0]  reg_o,
  output logic              valid_o
);

  logic [ADDR_W-1:0] hi;

  // Full-width window number so addresses beyond the last feature are still caught.
  assign hi      = addr_i >> REG_W;
  assign feat_o  = hi[FIDX_W-1:0];
  assign reg_o   = addr_i[REG_W-1:0];
  assign valid_o = (addr_i[2:0] == 3'b000) && (hi < ADDR_W'(NUM_FEAT));

endmodule

// File: rtl/dfh_chain_responder.sv
// rtl/dfh_chain_responder.sv - CSR leaf slave presenting a DFH chain with optional per-feature scratch.
// Scratch registers exist only when DFH_RESP_SCRATCH_EN is defined.
module dfh_chain_responder
  import dfh_resp_pkg::*;
#(
  parameter int                        NUM_FEAT   = 4,
  parameter int                        FEAT_SIZE  = 'h1000,
  parameter int                        ADDR_W     = 20,
  parameter logic [NUM_FEAT-1:0][11:0] FEAT_ID    = '0,
  parameter logic [NUM_FEAT-1:0][3:0]  FEAT_TYPE  = '0,
  parameter logic [NUM_FEAT-1:0][3:0]  FEAT_MAJOR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_wvalid,
  output logic              s_wready,
  input  logic [63:0]       s_wdata,
  input  logic [7:0]        s_wstrb,
  output logic              s_bvalid,
  input  logic              s_bready,
  output logic [1:0]        s_bresp,
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [ADDR_W-1:0] s_araddr,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [63:0]       s_rdata,
  output logic [1:0]        s_rresp
);

  localparam int REG_W  = $clog2(FEAT_SIZE);
  localparam int FIDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_RESP = 1'b1;
  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;

  logic [0:0]  r_state_q, r_state_d;
  logic [0:0]  w_state_q, w_state_d;
  logic        init_q;
  logic [63:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [1:0]  bresp_q, bresp_d;

  logic [FIDX_W-1:0] ar_feat, aw_feat;
  logic [REG_W-1:0]  ar_reg, aw_reg;
  logic              ar_ok, aw_ok;
  logic              ar_hs, aw_hs;

  dfh_resp_addr_dec #(
    .ADDR_W(ADDR_W), .NUM_FEAT(NUM_FEAT), .FEAT_SIZE(FEAT_SIZE), .REG_W(REG_W), .FIDX_W(FIDX_W)
  ) u_ar_dec (
    .addr_i(s_araddr), .feat_o(ar_feat), .reg_o(ar_reg), .valid_o(ar_ok)
  );

  dfh_resp_addr_dec #(
    .ADDR_W(ADDR_W), .NUM_FEAT(NUM_FEAT), .FEAT_SIZE(FEAT_SIZE), .REG_W(REG_W), .FIDX_W(FIDX_W)
  ) u_aw_dec (
    .addr_i(s_awaddr), .feat_o(aw_feat), .reg_o(aw_reg), .valid_o(aw_ok)
  );

  t_dfh dfh_words [NUM_FEAT];

  for (genvar i = 0; i < NUM_FEAT; i++) begin : g_dfh
    localparam logic EOL = (i == NUM_FEAT - 1);
    assign dfh_words[i] = build_dfh(FEAT_TYPE[i], FEAT_ID[i], FEAT_MAJOR[i], EOL,
                                    EOL ? 24'h0 : 24'(FEAT_SIZE));
  end

  // init_q keeps the ready outputs low until the first clock after reset release.
  assign s_arready = init_q && (r_state_q == R_IDLE);
  assign s_awready = init_q && (w_state_q == W_IDLE);
  assign s_wready  = s_awready;
  assign s_rvalid  = (r_state_q == R_RESP);
  assign s_bvalid  = (w_state_q == W_RESP);
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;
  assign s_bresp   = bresp_q;

  assign ar_hs = s_arvalid && s_arready;
  assign aw_hs = s_awvalid && s_wvalid && s_awready;

`ifdef DFH_RESP_SCRATCH_EN
  logic [63:0] scratch_q [NUM_FEAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FEAT; i++) scratch_q[i] <= '0;
    end else if (aw_hs && aw_ok && (aw_reg == REG_W'(SCRATCH_OFF))) begin
      for (int b = 0; b < 8; b++) begin
        if (s_wstrb[b]) scratch_q[aw_feat][b*8 +: 8] <= s_wdata[b*8 +: 8];
      end
    end
  end
`else
  logic unused_wr;
  assign unused_wr = ^{aw_feat, aw_reg, s_wdata, s_wstrb};
`endif

  always_comb begin
    rdata_d = '0;
    rresp_d = RESP_SLVERR;
    if (ar_ok) begin
      rresp_d = RESP_OKAY;
      if (ar_reg == REG_W'(DFH_OFF)) rdata_d = dfh_words[ar_feat];
`ifdef DFH_RESP_SCRATCH_EN
      else if (ar_reg == REG_W'(SCRATCH_OFF)) rdata_d = scratch_q[ar_feat];
`endif
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    w_state_d = w_state_q;
    bresp_d   = aw_ok ? RESP_OKAY : RESP_SLVERR;
    if (r_state_q == R_IDLE) begin
      if (ar_hs) r_state_d = R_RESP;
    end else if (s_rready) begin
      r_state_d = R_IDLE;
    end
    if (w_state_q == W_IDLE) begin
      if (aw_hs) w_state_d = W_RESP;
    end else if (s_bready) begin
      w_state_d = W_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
      init_q    <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      bresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      init_q    <= 1'b1;
      if (ar_hs) begin
        rdata_q <= rdata_d;
        rresp_q <= rresp_d;
      end
      if (aw_hs) bresp_q <= bresp_d;
    end
  end

endmodule

// File: tb/tb_dfh_chain_responder.sv
// tb/tb_dfh_chain_responder.sv - directed table-driven bench for dfh_chain_responder.
module tb_dfh_chain_responder;

`ifdef DFH_RESP_SCRATCH_EN
  localparam bit SCR = 1'b1;
`else
  localparam bit SCR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_awvalid = 0, s_wvalid = 0, s_bready = 0, s_arvalid = 0, s_rready = 0;
  logic [19:0] s_awaddr = '0, s_araddr = '0;
  logic [63:0] s_wdata = '0;
  logic [7:0]  s_wstrb = '0;
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [63:0] s_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dfh_chain_responder #(
    .NUM_FEAT(3), .FEAT_SIZE('h1000), .ADDR_W(20),
    .FEAT_ID({12'h014, 12'h001, 12'h000}),
    .FEAT_TYPE({4'h3, 4'h3, 4'h4}),
    .FEAT_MAJOR({4'h0, 4'h0, 4'h0})
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [19:0] a, output logic [63:0] d, output logic [1:0] r);
    int n = 0;
    @(negedge clk);
    s_arvalid = 1'b1;
    s_araddr  = a;
    while (!s_arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ar_accept_wait", 64'(n < 20), 64'd1);
    @(negedge clk);
    s_arvalid = 1'b0;
    chk("rvalid_latency", 64'(s_rvalid), 64'd1);
    d = s_rdata;
    r = s_rresp;
    s_rready = 1'b1;
    @(negedge clk);
    s_rready = 1'b0;
  endtask

  task automatic wr(input logic [19:0] a, input logic [63:0] d, input logic [7:0] s,
                    output logic [1:0] r);
    int n = 0;
    @(negedge clk);
    s_awvalid = 1'b1;
    s_wvalid  = 1'b1;
    s_awaddr  = a;
    s_wdata   = d;
    s_wstrb   = s;
    while (!(s_awready && s_wready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("aw_accept_wait", 64'(n < 20), 64'd1);
    @(negedge clk);
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    chk("bvalid_latency", 64'(s_bvalid), 64'd1);
    r = s_bresp;
    s_bready = 1'b1;
    @(negedge clk);
    s_bready = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [19:0] addr;
    logic [63:0] data;
    logic [1:0]  resp;
  } rd_vec_t;

  rd_vec_t rv [8];

  initial begin
    logic [63:0] d, d0;
    logic [1:0]  r;
    int cnt;
    bit  seen;

    rv[0] = '{"dfh0",       20'h00000, 64'h4000_0000_1000_0000, 2'b00};
    rv[1] = '{"dfh1",       20'h01000, 64'h3000_0000_1000_0001, 2'b00};
    rv[2] = '{"dfh2_eol",   20'h02000, 64'h3000_0100_0000_0014, 2'b00};
    rv[3] = '{"past_end",   20'h03000, 64'h0,                   2'b10};
    rv[4] = '{"misaligned", 20'h00004, 64'h0,                   2'b10};
    rv[5] = '{"other_off",  20'h00010, 64'h0,                   2'b00};
    rv[6] = '{"scratch1_0", 20'h01008, 64'h0,                   2'b00};
    rv[7] = '{"far_addr",   20'hFFFF8, 64'h0,                   2'b10};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_arready", 64'(s_arready), 64'd0);
    chk("rst_awready", 64'(s_awready), 64'd0);
    chk("rst_wready",  64'(s_wready),  64'd0);
    chk("rst_rvalid",  64'(s_rvalid),  64'd0);
    chk("rst_bvalid",  64'(s_bvalid),  64'd0);
    chk("rst_rdata",   s_rdata,        64'd0);
    chk("rst_resps",   64'({s_rresp, s_bresp}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_arready", 64'(s_arready), 64'd1);
    chk("post_rst_awready", 64'(s_awready), 64'd1);

    // Chain walk and decode table
    for (int i = 0; i < 8; i++) begin
      rd(rv[i].addr, d, r);
      chk({rv[i].name, "_data"}, d, rv[i].data);
      chk({rv[i].name, "_resp"}, 64'(r), 64'(rv[i].resp));
    end

    // Scratch byte-lane writes
    wr(20'h01008, 64'hDEAD_BEEF_0123_4567, 8'h0F, r);
    chk("scr_wr1_bresp", 64'(r), 64'd0);
    rd(20'h01008, d, r);
    chk("scr_rd1_data", d, SCR ? 64'h0000_0000_0123_4567 : 64'h0);
    chk("scr_rd1_resp", 64'(r), 64'd0);
    wr(20'h01008, 64'hAAAA_BBBB_CCCC_DDDD, 8'hF0, r);
    rd(20'h01008, d, r);
    chk("scr_rd2_data", d, SCR ? 64'hAAAA_BBBB_0123_4567 : 64'h0);

    // Error writes leave every scratch alone
    wr(20'h03008, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, r);
    chk("wr_past_end_bresp", 64'(r), 64'd2);
    wr(20'h0200C, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, r);
    chk("wr_misaligned_bresp", 64'(r), 64'd2);
    wr(20'h02010, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, r);
    chk("wr_other_off_bresp", 64'(r), 64'd0);
    rd(20'h00008, d, r);
    chk("err_scr0", d, 64'h0);
    rd(20'h01008, d, r);
    chk("err_scr1", d, SCR ? 64'hAAAA_BBBB_0123_4567 : 64'h0);
    rd(20'h02008, d, r);
    chk("err_scr2", d, 64'h0);

    // Lone AW or lone W must not be accepted
    seen = 1'b0;
    @(negedge clk);
    s_awvalid = 1'b1; s_awaddr = 20'h00008;
    repeat (3) begin @(negedge clk); seen |= s_bvalid; end
    s_awvalid = 1'b0; s_wvalid = 1'b1; s_wdata = 64'hFF; s_wstrb = 8'hFF;
    repeat (3) begin @(negedge clk); seen |= s_bvalid; end
    s_wvalid = 1'b0;
    chk("lone_valid_no_b", 64'(seen), 64'd0);

    // Read backpressure
    @(negedge clk);
    s_arvalid = 1'b1; s_araddr = 20'h00000;
    @(negedge clk);
    s_arvalid = 1'b0;
    d0 = s_rdata;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (!s_rvalid || s_arready || s_rdata !== 64'h4000_0000_1000_0000) cnt++;
      @(negedge clk);
    end
    chk("bp_hold_errors", 64'(cnt), 64'd0);
    chk("bp_data", d0, 64'h4000_0000_1000_0000);
    s_rready = 1'b1;
    @(negedge clk);
    s_rready = 1'b0;
    chk("bp_arready_back", 64'(s_arready), 64'd1);
    chk("bp_rvalid_drop", 64'(s_rvalid), 64'd0);

    // Same-cycle read and write of scratch 0
    @(negedge clk);
    s_arvalid = 1'b1; s_araddr = 20'h00008;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_awaddr = 20'h00008; s_wdata = 64'h55; s_wstrb = 8'hFF;
    @(negedge clk);
    s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
    chk("same_cyc_rvalid", 64'(s_rvalid), 64'd1);
    chk("same_cyc_bvalid", 64'(s_bvalid), 64'd1);
    chk("same_cyc_old_data", s_rdata, 64'h0);
    s_rready = 1'b1; s_bready = 1'b1;
    @(negedge clk);
    s_rready = 1'b0; s_bready = 1'b0;
    rd(20'h00008, d, r);
    chk("same_cyc_new_data", d, SCR ? 64'h55 : 64'h0);

    // Back-to-back throughput
    cnt = 0;
    s_rready = 1'b1; s_arvalid = 1'b1; s_araddr = 20'h01000;
    for (int i = 0; i < 8; i++) begin
      if (s_arvalid && s_arready) cnt++;
      @(negedge clk);
    end
    s_arvalid = 1'b0;
    @(negedge clk);
    s_rready = 1'b0;
    chk("b2b_reads", 64'(cnt), 64'd4);
    cnt = 0;
    s_bready = 1'b1; s_awvalid = 1'b1; s_wvalid = 1'b1; s_awaddr = 20'h00010; s_wstrb = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      if (s_awvalid && s_wvalid && s_awready) cnt++;
      @(negedge clk);
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    @(negedge clk);
    s_bready = 1'b0;
    chk("b2b_writes", 64'(cnt), 64'd4);

    // Reset while a B response is pending
    wr(20'h02008, 64'h77, 8'hFF, r);
    rd(20'h02008, d, r);
    chk("pre_rst_scr2", d, SCR ? 64'h77 : 64'h0);
    @(negedge clk);
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_awaddr = 20'h02008; s_wdata = 64'h99;
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    chk("mid_bvalid_set", 64'(s_bvalid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_bvalid_async_drop", 64'(s_bvalid), 64'd0);
    chk("mid_arready_low", 64'(s_arready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin @(negedge clk); seen |= s_bvalid; end
    chk("mid_no_replay", 64'(seen), 64'd0);
    rd(20'h02008, d, r);
    chk("mid_scr2_cleared", d, 64'h0);
    rd(20'h01008, d, r);
    chk("mid_scr1_cleared", d, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
